// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART boot loader.
// State encodings, frame marker bytes and bus widths.
package uart_loader_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned ADDR_W  = 30;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 16;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CNT_LO = 3'd1;
  localparam state_t ST_CNT_HI = 3'd2;
  localparam state_t ST_DATA   = 3'd3;
  localparam state_t ST_WRITE  = 3'd4;
  localparam state_t ST_CSUM   = 3'd5;
  localparam state_t ST_RESP   = 3'd6;

  localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;
  localparam logic [BYTE_W-1:0] ACK_BYTE  = 8'h06;
  localparam logic [BYTE_W-1:0] NAK_BYTE  = 8'h15;

endpackage

// File: rtl/uart_loader_word_assembler.sv
// Collects four little-endian bytes into one 32-bit word.
// The first byte received ends up in word[7:0].
module word_assembler
  import uart_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [DATA_W-1:0] word,
  output logic              word_done_c
);

  logic [1:0]        lane_q, lane_d;
  logic [DATA_W-1:0] shift_q, shift_d;

  // New bytes enter at the top so that after four shifts byte 0 sits in the low lane.
  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    if (clr) begin
      lane_d = 2'd0;
    end else if (byte_valid) begin
      lane_d  = lane_q + 2'd1;
      shift_d = {byte_in, shift_q[DATA_W-1:BYTE_W]};
    end
  end

  assign word_done_c = byte_valid && !clr && (lane_q == 2'd3);
  assign word        = shift_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_q  <= 2'd0;
      shift_q <= '0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/uart_loader.sv
// UART boot loader: takes A5/count/payload frames from the RX FIFO, writes words to RAM, answers ACK/NAK.
// Define LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte after the payload.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 30'h0,
  parameter int unsigned       MAX_WORDS = 2048
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] r_data,
  input  logic              rx_empty,
  output logic              rd_uart,
  output logic [BYTE_W-1:0] w_data,
  output logic              wr_uart,
  input  logic              tx_full,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              we,
  output logic              cpu_hold
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BYTE_W-1:0] w_data_q, w_data_d;
  logic              we_q, we_d;
  logic              wr_q, wr_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              ack_q, ack_d;
  logic              run_q;
  logic              consume_c, pop_c, asm_clr_c, word_done_c;
  logic [CNT_W-1:0]  cnt_new_c;
`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;
`endif

  // Pop is combinational so the head byte is taken in the cycle it is seen; never while pushing a reply.
  assign consume_c = (state_q == ST_IDLE) || (state_q == ST_CNT_LO) || (state_q == ST_CNT_HI) ||
                     (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign pop_c     = run_q && !wr_q && consume_c && !rx_empty;

  word_assembler u_asm (
    .clk         (clk),
    .reset       (reset),
    .clr         (asm_clr_c),
    .byte_valid  (pop_c && (state_q == ST_DATA)),
    .byte_in     (r_data),
    .word        (wdata),
    .word_done_c (word_done_c)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    w_data_d   = w_data_q;
    we_d       = 1'b0;
    wr_d       = 1'b0;
    cpu_hold_d = cpu_hold_q;
    ack_d      = ack_q;
    asm_clr_c  = 1'b0;
    cnt_new_c  = {r_data, count_q[BYTE_W-1:0]};
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pop_c && (r_data == SYNC_BYTE)) begin
          state_d    = ST_CNT_LO;
          cpu_hold_d = 1'b1;
          asm_clr_c  = 1'b1;
          idx_d      = '0;
          addr_d     = BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      ST_CNT_LO: begin
        if (pop_c) begin
          count_d = {count_q[CNT_W-1:BYTE_W], r_data};
          state_d = ST_CNT_HI;
        end
      end
      ST_CNT_HI: begin
        if (pop_c) begin
          count_d = cnt_new_c;
          if (cnt_new_c == '0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_RESP;
            ack_d   = 1'b1;
`endif
          end else if (32'(cnt_new_c) > 32'(MAX_WORDS)) begin
            state_d = ST_RESP;
            ack_d   = 1'b0;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (pop_c) begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ r_data;
`endif
          if (word_done_c) begin
            state_d = ST_WRITE;
            we_d    = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        idx_d  = idx_q + 16'd1;
        addr_d = addr_q + 30'd1;
        if ((idx_q + 16'd1) == count_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = ST_CSUM;
`else
          state_d = ST_RESP;
          ack_d   = 1'b1;
`endif
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (pop_c) begin
          ack_d   = (r_data == csum_q);
          state_d = ST_RESP;
        end
      end
`endif
      ST_RESP: begin
        if (!tx_full) begin
          wr_d     = 1'b1;
          w_data_d = ack_q ? ACK_BYTE : NAK_BYTE;
          state_d  = ST_IDLE;
          if (ack_q) cpu_hold_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      idx_q      <= '0;
      addr_q     <= BASE_ADDR;
      w_data_q   <= '0;
      we_q       <= 1'b0;
      wr_q       <= 1'b0;
      cpu_hold_q <= 1'b1;
      ack_q      <= 1'b0;
      run_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      w_data_q   <= w_data_d;
      we_q       <= we_d;
      wr_q       <= wr_d;
      cpu_hold_q <= cpu_hold_d;
      ack_q      <= ack_d;
      run_q      <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign rd_uart  = pop_c;
  assign w_data   = w_data_q;
  assign wr_uart  = wr_q;
  assign addr     = addr_q;
  assign we       = we_q;
  assign cpu_hold = cpu_hold_q;

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: FIFO-fed byte frames checked against a frame-level reference model.
// Follows LOADER_CHECKSUM_EN the same way as the design.
module tb_uart_loader;

  localparam logic [29:0] BASE = 30'h0;
  localparam int          MAXW = 2048;
  localparam int          WAIT_LIMIT = 40000;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  r_data = 8'h00;
  logic        rx_empty = 1'b1;
  logic        rd_uart;
  logic [7:0]  w_data;
  logic        wr_uart;
  logic        tx_full = 1'b0;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        cpu_hold;

  uart_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .r_data(r_data), .rx_empty(rx_empty), .rd_uart(rd_uart),
    .w_data(w_data), .wr_uart(wr_uart), .tx_full(tx_full), .addr(addr), .wdata(wdata),
    .we(we), .cpu_hold(cpu_hold)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed { logic [29:0] a; logic [31:0] d; } wr_t;
  typedef struct {
    logic [0:15][7:0] b;
    int               len;
    int               nwr;
    logic [31:0]      w0;
    logic [7:0]       resp;
    logic             hold;
  } vec_t;

  logic [7:0] fifo[$];
  logic [7:0] stim[$];
  wr_t        act_wr[$], exp_wr[$];
  logic [7:0] act_resp[$], exp_resp[$];
  logic       act_hold[$], exp_hold[$];
  logic       mdl_hold = 1'b1;
  int         gap_mode = 0;
  logic       gap = 1'b0;
  int         viol_rd = 0, viol_rw = 0;
  int         errors = 0, checks = 0;

  // RX FIFO model: the pop seen at an edge removes the head, new head is shown 1 time unit later.
  always @(posedge clk) begin
    bit did_pop;
    did_pop = rd_uart;
    #1;
    if (did_pop && fifo.size() > 0) void'(fifo.pop_front());
    case (gap_mode)
      1:       gap = ~gap;
      2:       gap = ($urandom_range(0, 2) == 0);
      default: gap = 1'b0;
    endcase
    rx_empty = (fifo.size() == 0) || gap;
    r_data   = (fifo.size() == 0) ? 8'h00 : fifo[0];
  end

  always @(negedge clk) begin
    if (we) act_wr.push_back('{a: addr, d: wdata});
    if (wr_uart) begin
      act_resp.push_back(w_data);
      act_hold.push_back(cpu_hold);
    end
    if (rd_uart && rx_empty) viol_rd++;
    if (rd_uart && wr_uart) viol_rw++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level reference: scan the byte stream, decode complete frames into writes and replies.
  function automatic void model_run();
    int         i, n;
    logic [7:0] x;
    logic [31:0] w;
    bit         ok;
    i = 0;
    while (i < stim.size()) begin
      if (stim[i] != 8'hA5) begin
        i++;
        continue;
      end
      if (i + 2 >= stim.size()) break;
      n = int'({stim[i+2], stim[i+1]});
      i += 3;
      mdl_hold = 1'b1;
      if (n > MAXW) begin
        exp_resp.push_back(8'h15);
        exp_hold.push_back(1'b1);
        continue;
      end
      if (i + 4 * n + int'(CS) > stim.size()) break;
      x = 8'h00;
      for (int k = 0; k < n; k++) begin
        w = {stim[i+4*k+3], stim[i+4*k+2], stim[i+4*k+1], stim[i+4*k]};
        x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
        exp_wr.push_back('{a: 30'(BASE + 30'(k)), d: w});
      end
      i += 4 * n;
      ok = 1'b1;
      if (CS) begin
        ok = (stim[i] == x);
        i++;
      end
      exp_resp.push_back(ok ? 8'h06 : 8'h15);
      exp_hold.push_back(!ok);
      if (ok) mdl_hold = 1'b0;
    end
  endfunction

  function automatic void add_frame(input int n, input bit good);
    logic [7:0] x, b;
    x = 8'h00;
    stim.push_back(8'hA5);
    stim.push_back(8'(n));
    stim.push_back(8'(n >> 8));
    if (n > MAXW) return;
    for (int k = 0; k < 4 * n; k++) begin
      b = 8'($urandom);
      stim.push_back(b);
      x ^= b;
    end
    if (CS) stim.push_back(good ? x : ~x);
  endfunction

  function automatic void add_fixed(input int ndata);
    logic [7:0] fx [0:10] = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int k = 0; k < 3 + ndata; k++) stim.push_back(fx[k]);
    // XOR of the eight payload bytes is 0x2A
    if (CS && ndata == 8) stim.push_back(8'h2A);
  endfunction

  task automatic clear_all();
    act_wr.delete(); exp_wr.delete();
    act_resp.delete(); exp_resp.delete();
    act_hold.delete(); exp_hold.delete();
  endtask

  task automatic wait_fifo_empty();
    int cyc = 0;
    while (fifo.size() != 0 && cyc < WAIT_LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    check("fifo_drain_timeout", 64'(cyc >= WAIT_LIMIT), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle(input int nresp);
    int cyc = 0;
    while ((fifo.size() != 0 || act_resp.size() < nresp) && cyc < WAIT_LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    check("frame_timeout", 64'(cyc >= WAIT_LIMIT), 64'(0));
    repeat (6) @(negedge clk);
  endtask

  task automatic compare_model();
    check("wr_count", 64'(act_wr.size()), 64'(exp_wr.size()));
    for (int i = 0; i < act_wr.size() && i < exp_wr.size(); i++) begin
      check($sformatf("wr%0d_addr", i), 64'(act_wr[i].a), 64'(exp_wr[i].a));
      check($sformatf("wr%0d_data", i), 64'(act_wr[i].d), 64'(exp_wr[i].d));
    end
    check("resp_count", 64'(act_resp.size()), 64'(exp_resp.size()));
    for (int i = 0; i < act_resp.size() && i < exp_resp.size(); i++) begin
      check($sformatf("resp%0d_byte", i), 64'(act_resp[i]), 64'(exp_resp[i]));
      check($sformatf("resp%0d_hold", i), 64'(act_hold[i]), 64'(exp_hold[i]));
    end
    check("hold_after", 64'(cpu_hold), 64'(mdl_hold));
  endtask

  task automatic run_frame();
    clear_all();
    model_run();
    foreach (stim[i]) fifo.push_back(stim[i]);
    wait_idle(exp_resp.size());
    compare_model();
  endtask

  task automatic check_reset_outputs();
    check("rst_cpu_hold", 64'(cpu_hold), 64'(1));
    check("rst_we", 64'(we), 64'(0));
    check("rst_rd_uart", 64'(rd_uart), 64'(0));
    check("rst_wr_uart", 64'(wr_uart), 64'(0));
    check("rst_addr", 64'(addr), 64'(BASE));
    check("rst_wdata", 64'(wdata), 64'(0));
    check("rst_w_data", 64'(w_data), 64'(0));
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{b: {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF,
                    8'hBE, 8'hAD, 8'hDE, 8'h2A, 8'h00, 8'h00, 8'h00, 8'h00},
                len: 12, nwr: 2, w0: 32'h12345678, resp: 8'h06, hold: 1'b0};
    vecs[1] = '{b: {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF,
                    8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                len: 12, nwr: 2, w0: 32'h12345678,
                resp: CS ? 8'h15 : 8'h06, hold: CS};
    vecs[2] = '{b: {8'h00, 8'hFF, 8'hA5, 8'h01, 8'h08, 8'h00, 8'h00, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                len: 5, nwr: 0, w0: 32'h0, resp: 8'h15, hold: 1'b1};
    vecs[3] = '{b: {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                len: 4, nwr: 0, w0: 32'h0, resp: 8'h06, hold: 1'b0};
    vecs[4] = '{b: {8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                len: 8, nwr: 1, w0: 32'h44332211, resp: 8'h06, hold: 1'b0};

    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Directed frames from the table
    foreach (vecs[v]) begin
      stim.delete();
      for (int j = 0; j < vecs[v].len; j++) stim.push_back(vecs[v].b[j]);
      run_frame();
      check($sformatf("vec%0d_nwr", v), 64'(act_wr.size()), 64'(vecs[v].nwr));
      if (vecs[v].nwr > 0 && act_wr.size() > 0) begin
        check($sformatf("vec%0d_w0", v), 64'(act_wr[0].d), 64'(vecs[v].w0));
        check($sformatf("vec%0d_a0", v), 64'(act_wr[0].a), 64'(BASE));
      end
      check($sformatf("vec%0d_nresp", v), 64'(act_resp.size()), 64'(1));
      if (act_resp.size() > 0) check($sformatf("vec%0d_resp", v), 64'(act_resp[0]), 64'(vecs[v].resp));
      check($sformatf("vec%0d_hold", v), 64'(cpu_hold), 64'(vecs[v].hold));
    end

    // Reply held off by a full TX FIFO
    stim.delete();
    add_fixed(8);
    clear_all();
    model_run();
    tx_full = 1'b1;
    foreach (stim[i]) fifo.push_back(stim[i]);
    wait_fifo_empty();
    repeat (20) @(negedge clk);
    check("txfull_no_resp", 64'(act_resp.size()), 64'(0));
    tx_full = 1'b0;
    wait_idle(exp_resp.size());
    compare_model();

    // Bytes arriving every other cycle
    gap_mode = 1;
    stim.delete();
    add_fixed(8);
    run_frame();
    gap_mode = 0;

    // Reset after the third data byte, then a fresh frame
    stim.delete();
    add_fixed(3);
    clear_all();
    foreach (stim[i]) fifo.push_back(stim[i]);
    wait_fifo_empty();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    reset = 1'b1;
    mdl_hold = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_write", 64'(act_wr.size()), 64'(0));
    check("abort_no_resp", 64'(act_resp.size()), 64'(0));
    stim.delete();
    add_fixed(8);
    run_frame();

    // Random frames with junk, bad checksums, oversize counts and irregular arrival
    gap_mode = 2;
    for (int f = 0; f < 10; f++) begin
      int n;
      stim.delete();
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        logic [7:0] jb;
        jb = 8'($urandom);
        stim.push_back(jb == 8'hA5 ? 8'h00 : jb);
      end
      n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(MAXW + 1, 65535)) : int'($urandom_range(1, 6));
      add_frame(n, $urandom_range(0, 3) != 0);
      run_frame();
    end
    gap_mode = 0;

    // Largest accepted frame
    stim.delete();
    add_frame(MAXW, 1'b1);
    run_frame();

    check("rd_while_empty", 64'(viol_rd), 64'(0));
    check("rd_wr_overlap", 64'(viol_rw), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
